// File: rtl/lwc_do_gearbox.sv
// LWC do_* output gearbox: buffers datapath words and serialises
// them MSB-first into bus beats under a valid/ready handshake.
module lwc_do_gearbox #(
  parameter  int BUSW  = 32,
  parameter  int INW   = 128,
  parameter  int DEPTH = 2,
  localparam int NB    = INW / BUSW,
  localparam int NBW   = $clog2(NB + 1),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [INW-1:0]  in_data,
  input  logic [NBW-1:0]  in_nbeats,
  input  logic            in_last,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [BUSW-1:0] do_data,
  output logic            do_valid,
  output logic            do_last,
  input  logic            do_ready,
  output logic [CW-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [INW-1:0]  mem_d_q [DEPTH];
  logic [NBW-1:0]  mem_n_q [DEPTH];
  logic [DEPTH-1:0] mem_l_q;

  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [NBW-1:0]  beat_q, beat_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BUSW-1:0] hold_q, hold_d;

  logic [INW-1:0]  head_sh;
  logic [BUSW-1:0] cur;
  logic [NBW-1:0]  head_nb;
  logic [NBW-1:0]  nb_eff;
  logic            end_beat;
  logic            push, adv, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign nb_eff = (in_nbeats == '0 || in_nbeats > NBW'(NB))
                ? NBW'(NB) : in_nbeats;

  assign head_nb  = mem_n_q[rd_q];
  assign head_sh  = mem_d_q[rd_q] << (beat_q * BUSW);
  assign cur      = head_sh[INW-1 -: BUSW];
  assign end_beat = (beat_q == head_nb - 1'b1);

  assign in_ready = (cnt_q < CW'(DEPTH));
  assign do_valid = (cnt_q != '0);
  assign count    = cnt_q;
  // Empty bus keeps showing the last consumed beat
  assign do_data  = do_valid ? cur : hold_q;
  assign do_last  = do_valid & mem_l_q[rd_q] & end_beat;

  assign push = in_valid & in_ready & ~flush;
  assign adv  = do_valid & do_ready & ~flush;
  assign pop  = adv & end_beat;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    beat_d = beat_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    if (flush) begin
      wr_d   = '0;
      rd_d   = '0;
      beat_d = '0;
      cnt_d  = '0;
      hold_d = '0;
    end else begin
      if (push) wr_d = nxt(wr_q);
      if (adv) begin
        hold_d = cur;
        if (end_beat) begin
          beat_d = '0;
          rd_d   = nxt(rd_q);
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      beat_q <= '0;
      cnt_q  <= '0;
      hold_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      beat_q <= beat_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_d_q[wr_q] <= in_data;
      mem_n_q[wr_q] <= nb_eff;
      mem_l_q[wr_q] <= in_last;
    end
  end

endmodule

// File: tb/tb_lwc_do_gearbox.sv
// Directed and randomized checks of lwc_do_gearbox against a
// beat-queue reference model.
module tb_lwc_do_gearbox;

  localparam int BUSW  = 32;
  localparam int INW   = 128;
  localparam int DEPTH = 2;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [127:0] in_data;
  logic [2:0]   in_nbeats;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  do_data;
  logic         do_valid;
  logic         do_last;
  logic         do_ready;
  logic [1:0]   count;

  lwc_do_gearbox #(.BUSW(BUSW), .INW(INW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_nbeats(in_nbeats),
    .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .do_data(do_data),
    .do_valid(do_valid), .do_last(do_last),
    .do_ready(do_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    bit          lb;
    bit          we;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] hold;
  int          n_vec;
  int          n_err;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_cnt();
    int c = 0;
    foreach (exp_q[i]) if (exp_q[i].we) c++;
    return c;
  endfunction

  task automatic chk_all();
    int c = model_cnt();
    bit v = (exp_q.size() != 0);
    chk("do_valid", 32'(do_valid), 32'(v));
    chk("do_data", do_data, v ? exp_q[0].d : hold);
    chk("do_last", 32'(do_last), v ? 32'(exp_q[0].lb) : 32'd0);
    chk("count", 32'(count), 32'(c));
    chk("in_ready", 32'(in_ready), 32'(c < DEPTH));
  endtask

  task automatic push_word(input logic [127:0] d, input int nb,
                           input bit l);
    int e = (nb == 0 || nb > 4) ? 4 : nb;
    for (int k = 0; k < e; k++) begin
      beat_t b;
      b.d  = 32'(d >> (INW - BUSW * (k + 1)));
      b.lb = l && (k == e - 1);
      b.we = (k == e - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic step(input bit iv, input logic [127:0] d,
                      input logic [2:0] nb, input bit il,
                      input bit dr, input bit fl, output bit acc);
    bit pop;
    in_valid  = iv;
    in_data   = d;
    in_nbeats = nb;
    in_last   = il;
    do_ready  = dr;
    flush     = fl;
    #1;
    chk_all();
    acc = iv && (model_cnt() < DEPTH) && !fl;
    pop = (exp_q.size() != 0) && dr && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      hold = '0;
    end else begin
      if (pop) begin
        hold = exp_q[0].d;
        void'(exp_q.pop_front());
      end
      if (acc) push_word(d, int'(nb), il);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    bit acc;
    int tries;
    logic [127:0] w;
    n_vec = 0;
    n_err = 0;
    hold  = '0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_nbeats = '0; in_last = 1'b0; do_ready = 1'b0;
    #12;
    chk_all();
    @(posedge clk); #1;
    rst = 1'b1;

    // Full word, known beats
    w = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    step(1, w, 3'd4, 1, 1, 0, acc);
    chk("spec_acc", 32'(acc), 32'd1);
    chk("beat0", do_data, 32'h00112233);
    for (int i = 0; i < 5; i++) step(0, '0, 0, 0, 1, 0, acc);
    chk("empty_hold", do_data, 32'hCCDDEEFF);

    // Partial words and nbeats normalisation
    step(1, rnd128(), 3'd2, 1, 1, 0, acc);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1, 0, acc);
    step(1, rnd128(), 3'd0, 1, 1, 0, acc);
    for (int i = 0; i < 5; i++) step(0, '0, 0, 0, 1, 0, acc);
    step(1, rnd128(), 3'd6, 0, 1, 0, acc);
    for (int i = 0; i < 5; i++) step(0, '0, 0, 0, 1, 0, acc);
    step(1, rnd128(), 3'd1, 1, 1, 0, acc);
    for (int i = 0; i < 2; i++) step(0, '0, 0, 0, 1, 0, acc);

    // Backpressure: third word waits for the first pop
    step(1, rnd128(), 3'd4, 0, 0, 0, acc);
    step(1, rnd128(), 3'd2, 1, 0, 0, acc);
    step(1, rnd128(), 3'd3, 1, 0, 0, acc);
    chk("full_rej", 32'(acc), 32'd0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 0, 0, acc);
    w = rnd128();
    tries = 0;
    acc = 0;
    while (!acc && tries < 20) begin
      step(1, w, 3'd3, 1, 1, 0, acc);
      tries++;
    end
    chk("third_tries", 32'(tries), 32'd5);
    for (int i = 0; i < 10; i++) step(0, '0, 0, 0, 1, 0, acc);

    // Concurrent push and final-beat pop
    step(1, rnd128(), 3'd1, 0, 1, 0, acc);
    step(1, rnd128(), 3'd2, 1, 1, 0, acc);
    chk("conc_cnt", 32'(count), 32'd1);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1, 0, acc);

    // Flush mid-word at beat 2
    step(1, rnd128(), 3'd4, 1, 1, 0, acc);
    step(0, '0, 0, 0, 1, 0, acc);
    step(0, '0, 0, 0, 1, 0, acc);
    step(1, rnd128(), 3'd4, 1, 0, 1, acc);
    chk("flush_dv", 32'(do_valid), 32'd0);
    step(1, rnd128(), 3'd3, 1, 1, 0, acc);
    for (int i = 0; i < 4; i++) step(0, '0, 0, 0, 1, 0, acc);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), rnd128(),
           3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
           acc);
    end

    // Asynchronous reset during traffic
    step(1, rnd128(), 3'd4, 1, 1, 0, acc);
    step(1, rnd128(), 3'd4, 1, 0, 0, acc);
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    hold = '0;
    chk_all();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(0, '0, 0, 0, 1, 0, acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
